cam_w48_d64: RTL and testbench
==============================

Name: cam_w48_d64

Overview:
- 64-entry, 48-bit-wide content-addressable memory for MAC learning tables, with per-entry aging.
- Provides:
  - single-cycle parallel search;
  - learn/write into a free slot;
  - table init;
  - aging sweep that evicts stale entries;
  - per-address age refresh.
- Sits between the MAC-learning/lookup logic and the forwarding engine; all control is via req/ack handshakes.

Parameters:
- AGE_MAX, 10'd3: number of aging passes an un-refreshed entry survives. It is evicted on pass AGE_MAX+1.

Ports:
- clk  in  1: single clock, rising edge.
- rstn  in  1: asynchronous, active-high reset. The port keeps the codebase name; asserted = 1.
- init_req  in  1: request to clear the whole table.
- init_ack  out  1: init complete.
- cam_search  in  1: one-cycle search strobe, compares cam_content.
- cam_content  in  48: search key / write data.
- cam_matched  out  1: search hit pulse.
- cam_mismatched  out  1: search miss pulse.
- cam_match_addr  out  6: index of the hit entry.
- cam_wr_req  in  1: learn cam_content.
- cam_wr_ack  out  1: write done.
- cam_wr_addr  out  6: index written (or existing duplicate).
- cam_refresh_req  in  1: clear age of one entry.
- cam_refresh_addr  in  6: entry to refresh.
- cam_refresh_ack  out  1: refresh done.
- aging_req  in  1: start aging sweep.
- aging_ack  out  1: sweep done.
- cam_empty  out  1: 1 when no entry is valid.

Behaviour:
- Storage per entry: valid bit, 48-bit key, 10-bit age.
- Reset clears every valid bit and age.
- Output reset values: all outputs 0 except cam_empty = 1.
- Handshake (init, write, refresh, aging):
  - Requests are levels.
  - ack rises when the operation completes and is held while req stays high.
  - ack drops the cycle after req is sampled low.
  - A new operation is accepted only after req has been seen low.
- Control FSM states: IDLE, INIT, WRITE, REFRESH, AGING, DONE (ack held, waiting for req low).
- Priority in IDLE: init > aging > write > refresh.
- Search:
  - Independent of the FSM and always serviced.
  - cam_search sampled at edge N → at edge N+1 exactly one of cam_matched / cam_mismatched pulses for one cycle.
  - Only valid entries compare.
  - cam_match_addr = lowest matching index, registered; it holds its last value on a miss.
  - During INIT, search reports mismatch.
- INIT: sweeps addresses 0..63, one per cycle, clearing valid and age (64 cycles), then DONE.
- WRITE: 2 cycles (compare, then commit).
  - If the key already exists in a valid entry: that entry's age is cleared; cam_wr_addr = its index.
  - Otherwise: the lowest-index invalid entry is loaded (valid=1, age=0) and cam_wr_addr = that index.
  - If the table is full: the entry with the highest age (lowest index on ties) is replaced.
  - cam_wr_addr is registered and held until the next write.
- REFRESH: age[cam_refresh_addr] := 0 in one cycle; valid is unchanged. Refreshing an invalid entry is harmless.
- AGING: sweeps 0..63, one entry per cycle. For each valid entry:
  - if age == AGE_MAX, clear valid;
  - else age += 1.
  - The age increment saturates at 10 bits.
- A search in the same cycle as a table update sees the pre-update contents.
- cam_empty is derived combinationally from the OR of the valid bits, then registered.
- Reset mid-operation aborts it; all state returns to reset values.

Optional Feature:
- Macro CAM_SEARCH_REFRESH_EN.
- When defined: a search hit also clears the hit entry's age on the cycle the hit is reported, unless an AGING or INIT sweep is in progress (the sweep wins).
- When undefined: search never modifies the table.

Decomposition:
- Package cam_pkg holds:
  - constants CAM_W=48, CAM_D=64, CAM_AW=6, AGE_W=10;
  - FSM state enum.
- One natural sub-module: cam_prio_enc64, a 64-bit priority encoder returning the lowest set index plus a found flag. It is reused for match lookup and free-slot search.

Test Plan:
- Reset, then init_req → init_ack after ~64 cycles; cam_empty=1; a search for 48'h10 gives cam_mismatched.
- Write keys 1..64 → cam_wr_addr 0..63 in order; cam_empty=0 after the first write.
- Search 48'h10 → cam_matched, cam_match_addr=15.
- Search 48'h20 → cam_matched, cam_match_addr=31.
- Search 48'hf0f1f2f3f4f5 → cam_mismatched.
- Three aging passes with AGE_MAX=3 → all 64 entries still hit.
- Refresh addr 16, then addr 1, then a fourth aging pass → only entries 16 and 1 (keys 17 and 2) still hit; key 48'h10 misses.
- Write an existing key, 48'h5 → cam_wr_addr=4 and no new slot is used.
- With the table full and all ages equal, a write of key 48'hAA → replaces index 0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants, FSM state type and age helper for the 64 x 48-bit MAC-learning CAM.
package cam_pkg;

    localparam int CAM_W  = 48;
    localparam int CAM_D  = 64;
    localparam int CAM_AW = 6;
    localparam int AGE_W  = 10;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WRITE,
        REFRESH,
        AGING,
        DONE
    } camState_t;

    // Age counters stick at all-ones rather than wrapping back to a fresh age.
    function automatic logic [AGE_W-1:0] ageInc(input logic [AGE_W-1:0] age);
        return (age == '1) ? age : age + 1'b1;
    endfunction

endpackage

// File: rtl/cam_prio_enc64.sv
// 64-bit priority encoder: index of the lowest set bit plus a found flag.
module cam_prio_enc64
    import cam_pkg::*;
(
    input  logic [CAM_D-1:0]  vec_i,
    output logic [CAM_AW-1:0] idx_o,
    output logic              found_o
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = CAM_D - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = CAM_AW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_w48_d64.sv
// 64-entry, 48-bit CAM with learn, init, aging sweep and age refresh.
// Optional macro CAM_SEARCH_REFRESH_EN: a search hit also clears the hit entry's age.
module cam_w48_d64
    import cam_pkg::*;
#(
    parameter logic [AGE_W-1:0] AGE_MAX = 10'd3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              init_req,
    output logic              init_ack,
    input  logic              cam_search,
    input  logic [CAM_W-1:0]  cam_content,
    output logic              cam_matched,
    output logic              cam_mismatched,
    output logic [CAM_AW-1:0] cam_match_addr,
    input  logic              cam_wr_req,
    output logic              cam_wr_ack,
    output logic [CAM_AW-1:0] cam_wr_addr,
    input  logic              cam_refresh_req,
    input  logic [CAM_AW-1:0] cam_refresh_addr,
    output logic              cam_refresh_ack,
    input  logic              aging_req,
    output logic              aging_ack,
    output logic              cam_empty
);

    logic [CAM_D-1:0]  valid_q, valid_d;
    logic [AGE_W-1:0]  age_q [CAM_D];
    logic [AGE_W-1:0]  age_d [CAM_D];
    logic [CAM_W-1:0]  key_q [CAM_D];

    camState_t         state_q, state_d;
    camState_t         doneOp_q, doneOp_d;
    logic [CAM_AW-1:0] ptr_q, ptr_d;
    logic              wrPhase_q, wrPhase_d;
    logic              wrDup_q, wrDup_d;
    logic [CAM_W-1:0]  wrKey_q, wrKey_d;
    logic [CAM_AW-1:0] wrTarget_q, wrTarget_d;
    logic [CAM_AW-1:0] wrAddr_q, wrAddr_d;
    logic [CAM_AW-1:0] refAddr_q, refAddr_d;
    logic              keyWe;

    logic              matched_q, mismatched_q, empty_q;
    logic [CAM_AW-1:0] matchAddr_q;

    logic [CAM_D-1:0]  matchVec;
    logic [CAM_AW-1:0] matchIdx, freeIdx, victimIdx;
    logic              matchFound, freeFound;
    logic [AGE_W-1:0]  victimAge;
    logic              opReq;

    always_comb begin
        for (int i = 0; i < CAM_D; i++) begin
            matchVec[i] = valid_q[i] && (key_q[i] == cam_content);
        end
    end

    cam_prio_enc64 uMatchEnc (
        .vec_i   (matchVec),
        .idx_o   (matchIdx),
        .found_o (matchFound)
    );

    cam_prio_enc64 uFreeEnc (
        .vec_i   (~valid_q),
        .idx_o   (freeIdx),
        .found_o (freeFound)
    );

    // Replacement victim when full: oldest entry, lowest index on ties.
    always_comb begin
        victimIdx = '0;
        victimAge = age_q[0];
        for (int i = 1; i < CAM_D; i++) begin
            if (age_q[i] > victimAge) begin
                victimAge = age_q[i];
                victimIdx = CAM_AW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        case (doneOp_q)
            INIT:    opReq = init_req;
            WRITE:   opReq = cam_wr_req;
            REFRESH: opReq = cam_refresh_req;
            AGING:   opReq = aging_req;
            default: opReq = 1'b0;
        endcase

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (init_req) begin
                    state_d = INIT;
                end else if (aging_req) begin
                    state_d = AGING;
                end else if (cam_wr_req) begin
                    state_d = WRITE;
                end else if (cam_refresh_req) begin
                    state_d = REFRESH;
                end
            end
            INIT, AGING: begin
                if (ptr_q == '1) begin
                    state_d = DONE;
                end
            end
            WRITE: begin
                if (wrPhase_q) begin
                    state_d = DONE;
                end
            end
            REFRESH: state_d = DONE;
            DONE: begin
                if (!opReq) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        init_ack        = 1'b0;
        cam_wr_ack      = 1'b0;
        cam_refresh_ack = 1'b0;
        aging_ack       = 1'b0;
        if (state_q == DONE) begin
            case (doneOp_q)
                INIT:    init_ack        = 1'b1;
                WRITE:   cam_wr_ack      = 1'b1;
                REFRESH: cam_refresh_ack = 1'b1;
                AGING:   aging_ack       = 1'b1;
                default: ;
            endcase
        end
    end

    // Table and operation-context updates for whichever operation is active.
    always_comb begin
        valid_d    = valid_q;
        age_d      = age_q;
        doneOp_d   = doneOp_q;
        ptr_d      = ptr_q;
        wrPhase_d  = wrPhase_q;
        wrDup_d    = wrDup_q;
        wrKey_d    = wrKey_q;
        wrTarget_d = wrTarget_q;
        wrAddr_d   = wrAddr_q;
        refAddr_d  = refAddr_q;
        keyWe      = 1'b0;

        case (state_q)
            IDLE: begin
                ptr_d     = '0;
                wrPhase_d = 1'b0;
                refAddr_d = cam_refresh_addr;
                if (state_d != IDLE) begin
                    doneOp_d = state_d;
                end
            end
            INIT: begin
                valid_d[ptr_q] = 1'b0;
                age_d[ptr_q]   = '0;
                ptr_d          = ptr_q + 1'b1;
            end
            AGING: begin
                if (valid_q[ptr_q]) begin
                    if (age_q[ptr_q] == AGE_MAX) begin
                        valid_d[ptr_q] = 1'b0;
                        age_d[ptr_q]   = '0;
                    end else begin
                        age_d[ptr_q] = ageInc(age_q[ptr_q]);
                    end
                end
                ptr_d = ptr_q + 1'b1;
            end
            WRITE: begin
                if (!wrPhase_q) begin
                    wrPhase_d = 1'b1;
                    wrKey_d   = cam_content;
                    wrDup_d   = matchFound;
                    if (matchFound) begin
                        wrTarget_d = matchIdx;
                    end else if (freeFound) begin
                        wrTarget_d = freeIdx;
                    end else begin
                        wrTarget_d = victimIdx;
                    end
                end else begin
                    age_d[wrTarget_q] = '0;
                    wrAddr_d          = wrTarget_q;
                    if (!wrDup_q) begin
                        valid_d[wrTarget_q] = 1'b1;
                        keyWe               = 1'b1;
                    end
                end
            end
            REFRESH: age_d[refAddr_q] = '0;
            default: ;
        endcase

`ifdef CAM_SEARCH_REFRESH_EN
        if (cam_search && matchFound && state_q != AGING && state_q != INIT) begin
            age_d[matchIdx] = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            valid_q    <= '0;
            for (int i = 0; i < CAM_D; i++) begin
                age_q[i] <= '0;
            end
            doneOp_q   <= IDLE;
            ptr_q      <= '0;
            wrPhase_q  <= 1'b0;
            wrDup_q    <= 1'b0;
            wrKey_q    <= '0;
            wrTarget_q <= '0;
            wrAddr_q   <= '0;
            refAddr_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            age_q      <= age_d;
            doneOp_q   <= doneOp_d;
            ptr_q      <= ptr_d;
            wrPhase_q  <= wrPhase_d;
            wrDup_q    <= wrDup_d;
            wrKey_q    <= wrKey_d;
            wrTarget_q <= wrTarget_d;
            wrAddr_q   <= wrAddr_d;
            refAddr_q  <= refAddr_d;
        end
    end

    // Keys need no reset: an entry only compares once its valid bit is set.
    always_ff @(posedge clk) begin
        if (keyWe) begin
            key_q[wrTarget_q] <= wrKey_q;
        end
    end

    // Search sees the table as it stood before this edge's update.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            matched_q    <= 1'b0;
            mismatched_q <= 1'b0;
            matchAddr_q  <= '0;
            empty_q      <= 1'b1;
        end else begin
            empty_q <= ~|valid_q;
            if (cam_search && matchFound && state_q != INIT) begin
                matched_q    <= 1'b1;
                mismatched_q <= 1'b0;
                matchAddr_q  <= matchIdx;
            end else begin
                matched_q    <= 1'b0;
                mismatched_q <= cam_search;
            end
        end
    end

    assign cam_matched    = matched_q;
    assign cam_mismatched = mismatched_q;
    assign cam_match_addr = matchAddr_q;
    assign cam_wr_addr    = wrAddr_q;
    assign cam_empty      = empty_q;

endmodule

// File: tb/tb_cam_w48_d64.sv
// Self-checking bench for cam_w48_d64: handshake ops plus a search scoreboard.
module tb_cam_w48_d64;

   logic        clk = 1'b0;
   logic        rstn;
   logic        init_req, init_ack;
   logic        cam_search;
   logic [47:0] cam_content;
   logic        cam_matched, cam_mismatched;
   logic [5:0]  cam_match_addr;
   logic        cam_wr_req, cam_wr_ack;
   logic [5:0]  cam_wr_addr;
   logic        cam_refresh_req;
   logic [5:0]  cam_refresh_addr;
   logic        cam_refresh_ack;
   logic        aging_req, aging_ack;
   logic        cam_empty;

   typedef struct {
      logic [47:0] key;
      logic        hit;
      logic [5:0]  addr;
   } searchVec_t;

   typedef struct {
      logic       hit;
      logic [5:0] addr;
   } expSearch_t;

   expSearch_t expQ[$];
   logic [5:0] expLastAddr = 6'd0;
   logic       searchSampled = 1'b0;
   int         errCnt = 0;
   int         chkCnt = 0;

   cam_w48_d64 dut (
      .clk              (clk),
      .rstn             (rstn),
      .init_req         (init_req),
      .init_ack         (init_ack),
      .cam_search       (cam_search),
      .cam_content      (cam_content),
      .cam_matched      (cam_matched),
      .cam_mismatched   (cam_mismatched),
      .cam_match_addr   (cam_match_addr),
      .cam_wr_req       (cam_wr_req),
      .cam_wr_ack       (cam_wr_ack),
      .cam_wr_addr      (cam_wr_addr),
      .cam_refresh_req  (cam_refresh_req),
      .cam_refresh_addr (cam_refresh_addr),
      .cam_refresh_ack  (cam_refresh_ack),
      .aging_req        (aging_req),
      .aging_ack        (aging_ack),
      .cam_empty        (cam_empty)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Hard stop in case some handshake never completes
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      chkCnt++;
      if (act !== exp) begin
         errCnt++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Remember which edges sampled a search so the checker knows when a result is due
   always @(posedge clk) begin
      searchSampled <= cam_search;
   end

   // Scoreboard: compare each registered search result against the oldest expectation
   always @(negedge clk) begin
      if (searchSampled) begin
         if (expQ.size() == 0) begin
            checkOutput("searchUnexpected", 64'd1, 64'd0);
         end else begin
            expSearch_t e;
            e = expQ.pop_front();
            checkOutput("searchMatched", {63'd0, cam_matched}, {63'd0, e.hit});
            checkOutput("searchMismatched", {63'd0, cam_mismatched}, {63'd0, !e.hit});
            checkOutput("searchAddr", {58'd0, cam_match_addr}, {58'd0, e.addr});
         end
      end
   end

   // One-cycle search strobe; the expected result is queued when the strobe is driven
   task automatic applyStimulus(input logic [47:0] key, input logic hit, input logic [5:0] addr);
      expSearch_t e;
      @(negedge clk);
      cam_search  = 1'b1;
      cam_content = key;
      if (hit) expLastAddr = addr;
      e.hit  = hit;
      e.addr = expLastAddr;
      expQ.push_back(e);
      @(negedge clk);
      cam_search = 1'b0;
   endtask

   function automatic logic ackOf(input int which);
      case (which)
         0:       return init_ack;
         1:       return cam_wr_ack;
         2:       return cam_refresh_ack;
         default: return aging_ack;
      endcase
   endfunction

   task automatic setReq(input int which, input logic v);
      case (which)
         0:       init_req        = v;
         1:       cam_wr_req      = v;
         2:       cam_refresh_req = v;
         default: aging_req       = v;
      endcase
   endtask

   // Full level handshake: raise req, wait (bounded) for ack, drop req, see ack fall
   task automatic runOp(input string name, input int which, output int cycles);
      bit seen;
      int n;
      seen = 1'b0;
      n    = 0;
      @(negedge clk);
      setReq(which, 1'b1);
      while (!seen && n < 300) begin
         @(negedge clk);
         n++;
         if (ackOf(which)) seen = 1'b1;
      end
      checkOutput({name, "AckSeen"}, {63'd0, seen}, 64'd1);
      cycles = n;
      setReq(which, 1'b0);
      @(negedge clk);
      checkOutput({name, "AckDrop"}, {63'd0, ackOf(which)}, 64'd0);
   endtask

   task automatic writeKey(input logic [47:0] key, input logic [5:0] expAddr);
      int cyc;
      cam_content = key;
      runOp("write", 1, cyc);
      checkOutput("wrAddr", {58'd0, cam_wr_addr}, {58'd0, expAddr});
   endtask

   task automatic refreshAddr(input logic [5:0] addr);
      int cyc;
      cam_refresh_addr = addr;
      runOp("refresh", 2, cyc);
   endtask

   task automatic fillTable();
      for (int k = 1; k <= 64; k++) begin
         writeKey(48'(k), 6'(k - 1));
         if (k == 1) checkOutput("emptyAfterFirstWrite", {63'd0, cam_empty}, 64'd0);
      end
   endtask

   initial begin
      searchVec_t vecs[6];
      int cyc;
      int waitN;

      vecs[0] = '{key: 48'h10,           hit: 1'b1, addr: 6'd15};
      vecs[1] = '{key: 48'h20,           hit: 1'b1, addr: 6'd31};
      vecs[2] = '{key: 48'hf0f1f2f3f4f5, hit: 1'b0, addr: 6'd0};
      vecs[3] = '{key: 48'h1,            hit: 1'b1, addr: 6'd0};
      vecs[4] = '{key: 48'h40,           hit: 1'b1, addr: 6'd63};
      vecs[5] = '{key: 48'h0,            hit: 1'b0, addr: 6'd0};

      rstn             = 1'b1;
      init_req         = 1'b0;
      cam_search       = 1'b0;
      cam_content      = '0;
      cam_wr_req       = 1'b0;
      cam_refresh_req  = 1'b0;
      cam_refresh_addr = '0;
      aging_req        = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("rstEmpty", {63'd0, cam_empty}, 64'd1);
      rstn = 1'b0;
      @(negedge clk);
      checkOutput("rstEmptyAfter", {63'd0, cam_empty}, 64'd1);
      checkOutput("rstPulses", {62'd0, cam_matched, cam_mismatched}, 64'd0);
      checkOutput("rstAcks", {60'd0, init_ack, cam_wr_ack, cam_refresh_ack, aging_ack}, 64'd0);
      checkOutput("rstAddrs", {52'd0, cam_wr_addr, cam_match_addr}, 64'd0);

      runOp("init", 0, cyc);
      checkOutput("initLatencyOk", {63'd0, (cyc >= 64 && cyc <= 66)}, 64'd1);
      checkOutput("emptyAfterInit", {63'd0, cam_empty}, 64'd1);
      applyStimulus(48'h10, 1'b0, 6'd0);

      fillTable();

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].key, vecs[i].hit, vecs[i].addr);
      end

      for (int p = 0; p < 3; p++) begin
         runOp("aging", 3, cyc);
      end
      for (int k = 1; k <= 64; k++) begin
         applyStimulus(48'(k), 1'b1, 6'(k - 1));
      end

      refreshAddr(6'd16);
      refreshAddr(6'd1);
      runOp("aging", 3, cyc);
      for (int k = 1; k <= 64; k++) begin
         applyStimulus(48'(k), (k == 2 || k == 17), 6'(k - 1));
      end

      runOp("init", 0, cyc);
      checkOutput("emptyAfterReinit", {63'd0, cam_empty}, 64'd1);
      fillTable();
      writeKey(48'h5, 6'd4);
      applyStimulus(48'h5, 1'b1, 6'd4);
      applyStimulus(48'h40, 1'b1, 6'd63);
      writeKey(48'hAA, 6'd0);
      applyStimulus(48'hAA, 1'b1, 6'd0);
      applyStimulus(48'h1, 1'b0, 6'd0);
      applyStimulus(48'h2, 1'b1, 6'd1);

      waitN = 0;
      while (expQ.size() != 0 && waitN < 20) begin
         @(negedge clk);
         waitN++;
      end
      checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
